serial_adder_ctrl: RTL and testbench

Bit-serial add controller that sequences a single 1-bit full-adder cell over a WIDTH-bit operand pair, one bit per clock, LSB first. Operands arrive through a valid/ready input handshake, and the carry is held in a flop between bit steps. The WIDTH-bit sum and carry-out leave through a valid/ready output handshake. It sits between a requester that cannot afford a WIDTH-bit ripple adder and the shared 1-bit adder datapath.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_adder_ctrl_fa_cell.sv | 13 +
 rtl/serial_adder_ctrl.sv | 119 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial add controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width; never below one bit so the counter always exists.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Purely combinational 1-bit full adder shared by the serial controller.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder step per clock, LSB first.
// Optional signed-overflow output is built in when SERIAL_ADDER_OVF_EN is defined.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] soma,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_sr_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             sum_s;
  logic             co_s;

  fa_cell u_fa (
    .a   (a_sr_r[0]),
    .b   (b_sr_r[0]),
    .cin (carry_r),
    .s   (sum_s),
    .co  (co_s)
  );

  // Control FSM plus operand/result shift registers and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_sr_r      <= {WIDTH{1'b0}};
      b_sr_r      <= {WIDTH{1'b0}};
      res_sr_r    <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sr_r     <= a;
            b_sr_r     <= b;
            carry_r    <= cin;
            cnt_r      <= {CW{1'b0}};
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB so the LSB ends up at bit 0 after WIDTH steps.
          res_sr_r <= {sum_s, res_sr_r[WIDTH-1:1]};
          a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
          carry_r  <= co_s;
          cnt_r    <= cnt_r + CW'(1);
          if (cnt_r == LAST_CNT) begin
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign soma      = res_sr_r;
  assign cout      = carry_r;

`ifdef SERIAL_ADDER_OVF_EN
  logic msb_carry_r;

  // Carry into the MSB is the carry register during the final RUN step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msb_carry_r <= 1'b0;
    end else if ((state_r == RUN) && (cnt_r == LAST_CNT)) begin
      msb_carry_r <= carry_r;
    end
  end

  assign ovf = (state_r == DONE) & (msb_carry_r ^ carry_r);
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): directed table, corner sequences, random traffic.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       cin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] soma;
  logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .soma      (soma),
`ifdef SERIAL_ADDER_OVF_EN
    .cout      (cout),
    .ovf       (ovf)
`else
    .cout      (cout)
`endif
  );

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vc;
    logic [7:0] es;
    logic       ec;
    logic       eo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the output handshake.
  task automatic do_job(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        input logic [7:0] es, input logic ec, input logic eo, input string nm);
    int n;
    check({nm, " in_ready before accept"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; a = ta; b = tb_; cin = tc;
    @(negedge clk);
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, " latency"}, 64'(n), 64'd8);
    check({nm, " soma"}, 64'(soma), 64'(es));
    check({nm, " cout"}, 64'(cout), 64'(ec));
`ifdef SERIAL_ADDER_OVF_EN
    check({nm, " ovf"}, 64'(ovf), 64'(eo));
`else
    if (eo === 1'bx) $display("note: unexpected x in ovf expectation");
`endif
    @(negedge clk);
    check({nm, " out_valid one cycle"}, 64'(out_valid), 64'd0);
    check({nm, " in_ready back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int n;
    int acc;
    int res;
    logic [8:0] q[$];
    logic [8:0] e;
    logic ir, ov;
    logic [7:0] s_v;
    logic c_v;

    vecs[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    vecs[9] = '{8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0};

    // Reset state
    #12;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset soma", 64'(soma), 64'd0);
    check("reset cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("reset ovf", 64'(ovf), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table, back-to-back with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      do_job(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].es, vecs[i].ec, vecs[i].eo,
             $sformatf("vec%0d", i));
    end

    // Backpressure: hold result 5 cycles while in_valid stays high
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'h3C; b = 8'h05; cin = 1'b0;
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp latency", 64'(n), 64'd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp out_valid held", 64'(out_valid), 64'd1);
      check("bp soma held", 64'(soma), 64'h41);
      check("bp cout held", 64'(cout), 64'd0);
      check("bp in_ready low", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp handshake out_valid", 64'(out_valid), 64'd0);
    check("bp handshake in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("bp second accepted", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp2 latency", 64'(n), 64'd8);
    check("bp2 soma", 64'(soma), 64'h33);
    check("bp2 cout", 64'(cout), 64'd0);
    @(negedge clk);

    // Reset in the middle of a job
    in_valid = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst in_ready", 64'(in_ready), 64'd1);
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst soma", 64'(soma), 64'd0);
    check("midrst cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) n++;
    end
    check("midrst no stale result", 64'(n), 64'd0);
    do_job(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "after_rst");

    // Random traffic with stalls on both sides
    acc = 0; res = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ir = in_ready; ov = out_valid; s_v = soma; c_v = cout;
      in_valid = 1'($urandom_range(0, 1));
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && ir) begin
        q.push_back({1'b0, a} + {1'b0, b} + {8'd0, cin});
        acc++;
      end
      if (ov && out_ready) begin
        res++;
        if (q.size() == 0) begin
          check("rand result without accept", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("rand sum", 64'({c_v, s_v}), 64'(e));
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      if (out_valid === 1'b1) begin
        e = q.pop_front();
        check("drain sum", 64'({cout, soma}), 64'(e));
        res++;
      end
      @(negedge clk);
      n++;
    end
    check("rand queue drained", 64'(q.size()), 64'd0);
    check("rand accept==result count", 64'(res), 64'(acc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
